// File: rtl/kernel_sweep_ctrl.sv
// kernel_sweep_ctrl: walks a 3x3 window over an IMG_W x IMG_H image, feeds the kernel
// datapath and writes each result. Define KSWEEP_BACKPRESSURE_EN to add the wr_ready handshake.
module kernel_sweep_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    ksel_in,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [23:0]   win0,
  output logic [23:0]   win1,
  output logic [23:0]   win2,
  output logic [1:0]    ksel,
  input  logic [15:0]   kresult,
`ifdef KSWEEP_BACKPRESSURE_EN
  input  logic          wr_ready,
`endif
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data
);

  if (IMG_W < 3) begin : g_bad_w
    $error("kernel_sweep_ctrl: IMG_W must be >= 3");
  end
  if (IMG_H < 3) begin : g_bad_h
    $error("kernel_sweep_ctrl: IMG_H must be >= 3");
  end

  localparam logic [AW-1:0] LAST_OX    = AW'(IMG_W - 3);
  localparam logic [AW-1:0] LAST_OY    = AW'(IMG_H - 3);
  localparam logic [AW-1:0] SRC_STRIDE = AW'(IMG_W);
  localparam logic [AW-1:0] DST_STRIDE = AW'(IMG_W - 2);

  typedef enum logic [2:0] {IDLE, PRIME, SHIFT, WRITE, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    cnt;
  logic [AW-1:0] ox;
  logic [AW-1:0] oy;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [1:0]    rd_col;
  logic [1:0]    rd_row;
  logic [AW-1:0] pix_addr;
  logic [AW-1:0] res_addr;
  logic          rd_valid_q;
  logic [1:0]    cap_row;
  logic          wr_advance;

`ifdef KSWEEP_BACKPRESSURE_EN
  assign wr_advance = wr_ready;
`else
  assign wr_advance = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = PRIME;
      PRIME: if (cnt == 4'd9) next_state = WRITE;
      SHIFT: if (cnt == 4'd3) next_state = WRITE;
      WRITE: begin
        if (wr_advance) begin
          if (ox < LAST_OX)      next_state = SHIFT;
          else if (oy < LAST_OY) next_state = PRIME;
          else                   next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Prime reads walk column-major: cnt 0..8 maps to (col, row) = (cnt/3, cnt%3).
  always_comb begin
    rd_col = 2'd0;
    rd_row = 2'd0;
    if (state == PRIME) begin
      case (cnt)
        4'd0, 4'd1, 4'd2: rd_col = 2'd0;
        4'd3, 4'd4, 4'd5: rd_col = 2'd1;
        default:          rd_col = 2'd2;
      endcase
      case (cnt)
        4'd0, 4'd3, 4'd6: rd_row = 2'd0;
        4'd1, 4'd4, 4'd7: rd_row = 2'd1;
        default:          rd_row = 2'd2;
      endcase
    end else if (state == SHIFT) begin
      rd_col = 2'd2;
      rd_row = cnt[1:0];
    end
  end

  assign pix_addr = src_q + (oy + AW'(rd_row)) * SRC_STRIDE + ox + AW'(rd_col);
  assign res_addr = dst_q + oy * DST_STRIDE + ox;

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      PRIME: begin
        busy = 1'b1;
        if (cnt <= 4'd8) begin
          rd_en   = 1'b1;
          rd_addr = pix_addr;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt <= 4'd2) begin
          rd_en   = 1'b1;
          rd_addr = pix_addr;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = res_addr;
        wr_data = kresult;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= 4'd0;
    else if (next_state != state) cnt <= 4'd0;
    else                         cnt <= cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ksel  <= 2'd0;
      src_q <= '0;
      dst_q <= '0;
      ox    <= '0;
      oy    <= '0;
    end else if (state == IDLE && start) begin
      ksel  <= ksel_in;
      src_q <= src_base;
      dst_q <= dst_base;
      ox    <= '0;
      oy    <= '0;
    end else if (state == WRITE && wr_advance) begin
      if (ox < LAST_OX) begin
        ox <= ox + 1'b1;
      end else begin
        ox <= '0;
        oy <= oy + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      cap_row    <= 2'd0;
    end else begin
      rd_valid_q <= rd_en;
      cap_row    <= rd_row;
    end
  end

  // Priming shifts each byte in from the right so three captures per row build
  // {left, centre, right}; a slide shifts once, then overwrites only the right byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win0 <= '0;
      win1 <= '0;
      win2 <= '0;
    end else if (state == SHIFT && cnt == 4'd0) begin
      win0 <= {win0[15:0], win0[7:0]};
      win1 <= {win1[15:0], win1[7:0]};
      win2 <= {win2[15:0], win2[7:0]};
    end else if (rd_valid_q) begin
      if (state == PRIME) begin
        case (cap_row)
          2'd0:    win0 <= {win0[15:0], rd_data};
          2'd1:    win1 <= {win1[15:0], rd_data};
          default: win2 <= {win2[15:0], rd_data};
        endcase
      end else begin
        case (cap_row)
          2'd0:    win0[7:0] <= rd_data;
          2'd1:    win1[7:0] <= rd_data;
          default: win2[7:0] <= rd_data;
        endcase
      end
    end
  end

endmodule
